rs_enc_lfsr: RTL and testbench

//  Systematic streaming RS(MSG_LEN+4, MSG_LEN) encoder over GF(2^8), t=2; transmit-side counterpart of the syndrome/KES/Chien decoder.

---
 rtl/rs_pkg.sv | 14 +
 rtl/rs_enc_lfsr_if.sv | 34 +++
 rtl/gf2m8_multi.sv | 21 ++
 rtl/rs_enc_lfsr_core.sv | 33 +++
 rtl/rs_enc_lfsr.sv | 124 ++++++++++++
 tb/tb_rs_enc_lfsr.sv | 252 +++++++++++++++++++++++++
 6 files changed

// File: rtl/rs_pkg.sv
// Shared constants for the GF(2^8) RS(n, n-4) encoder: field polynomial,
// generator g(x) = (x+a^0)(x+a^1)(x+a^2)(x+a^3) coefficients and the FSM state type.
package rs_pkg;
  localparam logic [8:0] GF_POLY = 9'h11D;
  localparam int         NPAR    = 4;
  localparam logic [7:0] G3 = 8'h0F;
  localparam logic [7:0] G2 = 8'h36;
  localparam logic [7:0] G1 = 8'h78;
  localparam logic [7:0] G0 = 8'h40;
  // GEN[i] is the tap feeding LFSR stage p[i]
  localparam logic [NPAR-1:0][7:0] GEN = {G3, G2, G1, G0};

  typedef enum logic {MSG, PAR} enc_state_e;
endpackage

// File: rtl/rs_enc_lfsr_if.sv
// Stream bundle for the RS encoder: message input stream and codeword output stream.
// RS_ENC_ERRINJ_EN adds the error-injection request signals.
interface rs_enc_lfsr_if;
  logic       enc_in_vld;
  logic       enc_in_rdy;
  logic [7:0] enc_in_data;
  logic       enc_out_vld;
  logic       enc_out_rdy;
  logic [7:0] enc_out_data;
  logic       enc_out_sop;
  logic       enc_out_eop;
  logic       enc_out_par;
`ifdef RS_ENC_ERRINJ_EN
  logic       enc_err_arm;
  logic [7:0] enc_err_pos;
  logic [7:0] enc_err_mask;
`endif

  modport master (
`ifdef RS_ENC_ERRINJ_EN
    output enc_err_arm, enc_err_pos, enc_err_mask,
`endif
    output enc_in_vld, enc_in_data, enc_out_rdy,
    input  enc_in_rdy, enc_out_vld, enc_out_data, enc_out_sop, enc_out_eop, enc_out_par
  );

  modport slave (
`ifdef RS_ENC_ERRINJ_EN
    input  enc_err_arm, enc_err_pos, enc_err_mask,
`endif
    input  enc_in_vld, enc_in_data, enc_out_rdy,
    output enc_in_rdy, enc_out_vld, enc_out_data, enc_out_sop, enc_out_eop, enc_out_par
  );
endinterface

// File: rtl/gf2m8_multi.sv
// Combinational GF(2^8) multiplier, z = x*y mod GF_POLY.
module gf2m8_multi
  import rs_pkg::*;
(
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [7:0] z
);
  logic [7:0] acc;
  logic [7:0] a;

  always_comb begin
    acc = '0;
    a   = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) acc = acc ^ a;
      a = a[7] ? ((a << 1) ^ GF_POLY[7:0]) : (a << 1);
    end
    z = acc;
  end
endmodule

// File: rtl/rs_enc_lfsr_core.sv
// Parity LFSR: divides the message by g(x) on load, shifts remainder out (zero fill) on shift.
module rs_enc_lfsr_core
  import rs_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] din,
  output logic [7:0] par_out
);
  logic [NPAR-1:0][7:0] p, p_up, p_nxt, prod;
  logic [7:0]           fb;

  assign fb      = din ^ p[NPAR-1];
  assign par_out = p[NPAR-1];
  assign p_up    = {p[NPAR-2:0], 8'h00};

  for (genvar i = 0; i < NPAR; i++) begin : g_tap
    gf2m8_multi u_mul (.x(fb), .y(GEN[i]), .z(prod[i]));
  end

  always_comb begin
    p_nxt = p;
    if (load)       p_nxt = p_up ^ prod;
    else if (shift) p_nxt = p_up;
  end

  always_ff @(posedge clk) begin
    if (rst) p <= '0;
    else     p <= p_nxt;
  end
endmodule

// File: rtl/rs_enc_lfsr.sv
// Systematic streaming RS(MSG_LEN+4, MSG_LEN) encoder: message passthrough then 4 parity symbols.
// Optional RS_ENC_ERRINJ_EN: XORs a mask into one armed codeword symbol.
module rs_enc_lfsr
  import rs_pkg::*;
#(
  parameter int MSG_LEN = 251
)(
  input  logic         clk,
  input  logic         rst,
  rs_enc_lfsr_if.slave bus
);
  enc_state_e state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       free, in_rdy, in_xfer, par_step;
  logic [7:0] par_out, sym, sym_o;
  logic       out_vld, out_sop, out_eop, out_par;
  logic [7:0] out_data;

  assign free     = !out_vld | bus.enc_out_rdy;
  assign in_rdy   = !rst & (state == MSG) & free;
  assign in_xfer  = bus.enc_in_vld & in_rdy;
  assign par_step = !rst & (state == PAR) & free;
  assign sym      = in_xfer ? bus.enc_in_data : par_out;

  rs_enc_lfsr_core u_core (
    .clk(clk), .rst(rst), .load(in_xfer), .shift(par_step),
    .din(bus.enc_in_data), .par_out(par_out)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (in_xfer) begin
      if (cnt == 8'(MSG_LEN-1)) begin
        cnt_nxt   = '0;
        state_nxt = PAR;
      end else cnt_nxt = cnt + 8'd1;
    end else if (par_step) begin
      if (cnt == 8'(NPAR-1)) begin
        cnt_nxt   = '0;
        state_nxt = MSG;
      end else cnt_nxt = cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MSG;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef RS_ENC_ERRINJ_EN
  // A request waits in pend_* until a codeword starts, then moves to act_* for that codeword.
  logic       pend, act, start, live, hit;
  logic [7:0] pend_pos, pend_mask, act_pos, act_mask, cur_pos, cur_mask;
  logic [8:0] idx;

  assign start    = in_xfer & (cnt == 8'd0);
  assign live     = start ? (bus.enc_err_arm | pend) : act;
  assign cur_pos  = start ? (bus.enc_err_arm ? bus.enc_err_pos  : pend_pos)  : act_pos;
  assign cur_mask = start ? (bus.enc_err_arm ? bus.enc_err_mask : pend_mask) : act_mask;
  assign idx      = (state == MSG) ? {1'b0, cnt} : 9'(MSG_LEN) + {1'b0, cnt};
  assign hit      = live & (in_xfer | par_step) & (idx == {1'b0, cur_pos});
  assign sym_o    = sym ^ (hit ? cur_mask : 8'h00);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
      act  <= 1'b0;
    end else begin
      if (start) begin
        act      <= live;
        act_pos  <= cur_pos;
        act_mask <= cur_mask;
        pend     <= 1'b0;
      end else begin
        if (par_step && cnt == 8'(NPAR-1)) act <= 1'b0;
        if (bus.enc_err_arm) begin
          pend      <= 1'b1;
          pend_pos  <= bus.enc_err_pos;
          pend_mask <= bus.enc_err_mask;
        end
      end
    end
  end
`else
  assign sym_o = sym;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_sop  <= 1'b0;
      out_eop  <= 1'b0;
      out_par  <= 1'b0;
    end else if (in_xfer) begin
      out_vld  <= 1'b1;
      out_data <= sym_o;
      out_sop  <= (cnt == 8'd0);
      out_eop  <= 1'b0;
      out_par  <= 1'b0;
    end else if (par_step) begin
      out_vld  <= 1'b1;
      out_data <= sym_o;
      out_sop  <= 1'b0;
      out_eop  <= (cnt == 8'(NPAR-1));
      out_par  <= 1'b1;
    end else if (bus.enc_out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

  assign bus.enc_in_rdy   = in_rdy;
  assign bus.enc_out_vld  = out_vld;
  assign bus.enc_out_data = out_data;
  assign bus.enc_out_sop  = out_sop;
  assign bus.enc_out_eop  = out_eop;
  assign bus.enc_out_par  = out_par;
endmodule

// File: tb/tb_rs_enc_lfsr.sv
// Bench for rs_enc_lfsr: MSG_LEN=1 vector table, MSG_LEN=251 random/throttled/reset runs
// against a polynomial long-division model and syndrome evaluation.
module tb_rs_enc_lfsr;
  localparam int L = 251;
  localparam int N = L + 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rs_enc_lfsr_if if0();
  rs_enc_lfsr_if if1();
  rs_enc_lfsr #(.MSG_LEN(L)) u0 (.clk(clk), .rst(rst), .bus(if0));
  rs_enc_lfsr #(.MSG_LEN(1)) u1 (.clk(clk), .rst(rst), .bus(if1));

`ifdef RS_ENC_ERRINJ_EN
  initial begin
    if0.enc_err_arm = 1'b0; if0.enc_err_pos = '0; if0.enc_err_mask = '0;
    if1.enc_err_arm = 1'b0; if1.enc_err_pos = '0; if1.enc_err_mask = '0;
  end
`endif

  typedef logic [10:0] sym_t;  // {sop, eop, par, data}
  typedef struct packed { logic [7:0] m; logic [31:0] p; } vec_t;

  int total = 0, bad = 0, cyc = 0, rdy_mode = 0;
  sym_t q0[$], q1[$], expq[$];
  int   t0[$], t1[$];
  logic [7:0] stim[$], stim1[$];
  logic [7:0] gpoly [5] = '{8'h01, 8'h0F, 8'h36, 8'h78, 8'h40};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // output monitors plus hold-while-stalled check on u0
  sym_t h0;
  bit   stall0 = 1'b0;
  always @(negedge clk) begin
    if (stall0)
      chk("hold", {if0.enc_out_sop, if0.enc_out_eop, if0.enc_out_par, if0.enc_out_data}, h0);
    stall0 <= if0.enc_out_vld & !if0.enc_out_rdy & !rst;
    h0     <= {if0.enc_out_sop, if0.enc_out_eop, if0.enc_out_par, if0.enc_out_data};
    if (if0.enc_out_vld && if0.enc_out_rdy && !rst) begin
      q0.push_back({if0.enc_out_sop, if0.enc_out_eop, if0.enc_out_par, if0.enc_out_data});
      t0.push_back(cyc);
    end
    if (if1.enc_out_vld && if1.enc_out_rdy && !rst) begin
      q1.push_back({if1.enc_out_sop, if1.enc_out_eop, if1.enc_out_par, if1.enc_out_data});
      t1.push_back(cyc);
    end
  end

  initial forever begin
    @(posedge clk); #2;
    case (rdy_mode)
      0:       if0.enc_out_rdy = 1'b1;
      1:       if0.enc_out_rdy = 1'($urandom % 2);
      default: if0.enc_out_rdy = 1'b0;
    endcase
  end

  // polynomial product then reduction by x^8+x^4+x^3+x^2+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011D << (i - 8));
    return p[7:0];
  endfunction

  // append one codeword: message to stim, expected symbols to expq (remainder of m(x)x^4 / g(x))
  task automatic add_cw(input bit rnd);
    logic [7:0] c[$];
    logic [7:0] q, m;
    for (int i = 0; i < L; i++) begin
      m = rnd ? 8'($urandom) : 8'h00;
      c.push_back(m);
      stim.push_back(m);
      expq.push_back({(i == 0), 1'b0, 1'b0, m});
    end
    for (int i = 0; i < 4; i++) c.push_back(8'h00);
    for (int i = 0; i < L; i++) begin
      q = c[i];
      for (int j = 1; j <= 4; j++) c[i+j] = c[i+j] ^ gmul(q, gpoly[j]);
    end
    for (int k = 0; k < 4; k++) expq.push_back({1'b0, (k == 3), 1'b1, c[L+k]});
  endtask

  task automatic drive0(input bit thr);
    int i = 0, guard = 0;
    bit xf;
    @(posedge clk); #1;
    while (i < stim.size() && guard < 40000) begin
      if0.enc_in_vld  = thr ? 1'($urandom % 2) : 1'b1;
      if0.enc_in_data = stim[i];
      @(negedge clk);
      xf = if0.enc_in_vld & if0.enc_in_rdy;
      @(posedge clk); #1;
      if (xf) i++;
      guard++;
    end
    if0.enc_in_vld = 1'b0;
    if (i < stim.size()) chk("drive0_timeout", i, stim.size());
  endtask

  task automatic drive1();
    int i = 0, guard = 0;
    bit xf;
    @(posedge clk); #1;
    while (i < stim1.size() && guard < 1000) begin
      if1.enc_in_vld  = 1'b1;
      if1.enc_in_data = stim1[i];
      @(negedge clk);
      xf = if1.enc_in_vld & if1.enc_in_rdy;
      @(posedge clk); #1;
      if (xf) i++;
      guard++;
    end
    if1.enc_in_vld = 1'b0;
    if (i < stim1.size()) chk("drive1_timeout", i, stim1.size());
  endtask

  task automatic wait0(input int n, input int lim);
    int g = 0;
    while (q0.size() < n && g < lim) begin
      @(posedge clk);
      g++;
    end
    chk("q0_count", q0.size(), n);
  endtask

  task automatic cmp0();
    for (int i = 0; i < expq.size(); i++)
      if (i < q0.size()) chk("cw_sym", q0[i], expq[i]);
  endtask

  task automatic synd0(input int ncw);
    logic [7:0] s, ak;
    for (int w = 0; w < ncw; w++)
      for (int k = 0; k < 4; k++) begin
        s  = 8'h00;
        ak = 8'h01 << k;
        for (int j = 0; j < N; j++)
          if (w*N + j < q0.size()) s = gmul(s, ak) ^ q0[w*N + j][7:0];
        chk("syndrome", s, 8'h00);
      end
  endtask

  vec_t tbl[4];
  sym_t keep_exp[$];
  logic [7:0] keep_stim[$];

  initial begin
    tbl[0] = '{m: 8'h01, p: 32'h0F367840};
    tbl[1] = '{m: 8'h02, p: 32'h1E6CF080};
    tbl[2] = '{m: 8'h03, p: 32'h115A88C0};
    tbl[3] = '{m: 8'h00, p: 32'h00000000};

    rst = 1'b1;
    if0.enc_in_vld = 1'b0; if0.enc_in_data = '0; if0.enc_out_rdy = 1'b1;
    if1.enc_in_vld = 1'b0; if1.enc_in_data = '0; if1.enc_out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_rdy",   if0.enc_in_rdy, 0);
    chk("rst_out_vld",  if0.enc_out_vld, 0);
    chk("rst_out_data", if0.enc_out_data, 0);
    chk("rst_flags",    {if0.enc_out_sop, if0.enc_out_eop, if0.enc_out_par}, 0);
    chk("rst_in_rdy1",  if1.enc_in_rdy, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("in_rdy_after_rst", if0.enc_in_rdy, 1);

    // MSG_LEN=1 table, back-to-back
    foreach (tbl[e]) stim1.push_back(tbl[e].m);
    drive1();
    repeat (10) @(posedge clk);
    chk("tbl_count", q1.size(), 20);
    foreach (tbl[e]) begin
      if (5*e + 4 < q1.size()) begin
        chk("tbl_msg", q1[5*e], {3'b100, tbl[e].m});
        for (int k = 0; k < 4; k++)
          chk("tbl_par", q1[5*e+1+k], {1'b0, (k == 3), 1'b1, tbl[e].p[31-8*k -: 8]});
      end
    end
    if (t1.size() == 20) chk("tbl_gapless", t1[19] - t1[0], 19);

    // all-zero, two codewords back-to-back
    q0.delete(); t0.delete(); stim.delete(); expq.delete();
    add_cw(1'b0); add_cw(1'b0);
    drive0(1'b0);
    wait0(2*N, 2000);
    cmp0();
    if (q0.size() == 2*N) begin
      chk("zero_eop254", q0[254][9], 1);
      chk("zero_sop255", q0[255][10], 1);
      chk("zero_gapless", t0[2*N-1] - t0[0], 2*N-1);
    end

    // random, unthrottled
    q0.delete(); t0.delete(); stim.delete(); expq.delete();
    repeat (3) add_cw(1'b1);
    keep_stim = stim; keep_exp = expq;
    drive0(1'b0);
    wait0(3*N, 3000);
    cmp0();
    synd0(3);

    // same messages, 50% throttling on both sides
    q0.delete(); t0.delete(); stim = keep_stim; expq = keep_exp;
    rdy_mode = 1;
    drive0(1'b1);
    wait0(3*N, 8000);
    rdy_mode = 0;
    cmp0();
    synd0(3);
    repeat (5) @(posedge clk);

    // reset after 100 symbols, with one output pending
    q0.delete(); t0.delete(); stim.delete(); expq.delete();
    add_cw(1'b1);
    stim = stim[0:99];
    drive0(1'b0);
    rdy_mode = 2;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_rdy", if0.enc_in_rdy, 0);
    chk("midrst_pre_count", q0.size(), 99);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_out_vld", if0.enc_out_vld, 0);
    @(posedge clk); #1;
    rst = 1'b0; rdy_mode = 0;
    q0.delete(); t0.delete(); stim.delete(); expq.delete();
    add_cw(1'b1);
    drive0(1'b0);
    wait0(N, 2000);
    cmp0();
    synd0(1);
    repeat (20) @(posedge clk);
    chk("midrst_no_extra", q0.size(), N);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
